// File: rtl/cmp_seq_ctrl.sv
// Sequential magnitude comparator controller.
// Two operands are captured on a valid/ready handshake and compared one
// nibble per cycle, most-significant nibble first, using a single shared
// 4-bit comparator. The result (gt/eq/lt plus the number of nibble
// compares performed) is held until the consumer accepts it.

module cmp_seq_ctrl #(
   parameter int N_NIB      = 4,
   parameter int EARLY_EXIT = 1,
   parameter int SIGNED     = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [4*N_NIB-1:0]   a,
   input  logic [4*N_NIB-1:0]   b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 gt,
   output logic                 eq,
   output logic                 lt,
   output logic [3:0]           nib_cnt
);

   // Index of the most-significant nibble, where every compare starts and
   // where the sign lives when operands are two's complement.
   localparam logic [2:0] MS_IDX = 3'(N_NIB - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPARE = 2'd1,
      DONE    = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [4*N_NIB-1:0]    opA_q, opA_d;
   logic [4*N_NIB-1:0]    opB_q, opB_d;
   logic [2:0]            idx_q, idx_d;
   logic [3:0]            nibCnt_q, nibCnt_d;
   logic                  gt_q, gt_d;
   logic                  eq_q, eq_d;
   logic                  lt_q, lt_d;

   logic [3:0]            nibA;
   logic [3:0]            nibB;
   logic                  nibGt;
   logic                  nibLt;
   logic                  diffNow;
   logic                  resolved;
   logic                  firstDiff;
   logic                  lastNib;
   logic                  exitNow;

   // Shared nibble comparator: pick nibble idx of both captured operands and
   // flip the sign bit on the MS nibble in signed mode so that an unsigned
   // compare orders negative values below positive ones.
   always_comb begin
      nibA = 4'd0;
      nibB = 4'd0;
      for (int i = 0; i < N_NIB; i++) begin
         if (idx_q == 3'(i)) begin
            nibA = opA_q[4*i +: 4];
            nibB = opB_q[4*i +: 4];
         end
      end
      if ((SIGNED != 0) && (idx_q == MS_IDX)) begin
         nibA[3] = ~nibA[3];
         nibB[3] = ~nibB[3];
      end
      nibGt = (nibA > nibB);
      nibLt = (nibA < nibB);
   end

   // Compare bookkeeping: once gt or lt has been latched the result is
   // settled, so only the first differing nibble may set the flags.
   always_comb begin
      diffNow   = nibGt | nibLt;
      resolved  = gt_q | lt_q;
      firstDiff = diffNow & ~resolved;
      lastNib   = (idx_q == 3'd0);
      exitNow   = lastNib | ((EARLY_EXIT != 0) & firstDiff);
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: accept in IDLE, walk nibbles in COMPARE, and wait in
   // DONE until the consumer takes the result. There is no IDLE bypass.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = COMPARE;
            end
         end
         COMPARE: begin
            if (exitNow) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Handshake outputs and result flags, all decoded from registers.
   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      gt        = gt_q;
      eq        = eq_q;
      lt        = lt_q;
      nib_cnt   = nibCnt_q;
   end

   // Datapath next values: capture and clear on acceptance, then step the
   // nibble index down while counting compares and latching the first
   // difference. eq is only declared after the LS nibble shows no difference.
   always_comb begin
      opA_d    = opA_q;
      opB_d    = opB_q;
      idx_d    = idx_q;
      nibCnt_d = nibCnt_q;
      gt_d     = gt_q;
      eq_d     = eq_q;
      lt_d     = lt_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               opA_d    = a;
               opB_d    = b;
               idx_d    = MS_IDX;
               nibCnt_d = 4'd0;
               gt_d     = 1'b0;
               eq_d     = 1'b0;
               lt_d     = 1'b0;
            end
         end
         COMPARE: begin
            nibCnt_d = nibCnt_q + 4'd1;
            if (firstDiff) begin
               gt_d = nibGt;
               lt_d = nibLt;
            end
            if (lastNib && !resolved && !diffNow) begin
               eq_d = 1'b1;
            end
            if (!exitNow) begin
               idx_d = idx_q - 3'd1;
            end
         end
         default: begin
         end
      endcase
   end

   // Datapath registers; reset clears everything so an aborted compare
   // leaves no trace in the outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opA_q    <= '0;
         opB_q    <= '0;
         idx_q    <= 3'd0;
         nibCnt_q <= 4'd0;
         gt_q     <= 1'b0;
         eq_q     <= 1'b0;
         lt_q     <= 1'b0;
      end else begin
         opA_q    <= opA_d;
         opB_q    <= opB_d;
         idx_q    <= idx_d;
         nibCnt_q <= nibCnt_d;
         gt_q     <= gt_d;
         eq_q     <= eq_d;
         lt_q     <= lt_d;
      end
   end

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// Testbench for cmp_seq_ctrl. Three instances run in lock-step on shared
// inputs: unsigned early-exit (index 0), signed early-exit (index 1) and
// unsigned constant-time (index 2). Each operation waits until all three
// have a result before releasing them together, so they stay in step.

module tb_cmp_seq_ctrl;

   localparam int NN = 4;
   localparam int W  = 4 * NN;

   localparam logic [2:0] GT = 3'b100;
   localparam logic [2:0] EQ = 3'b010;
   localparam logic [2:0] LT = 3'b001;

   logic          clk       = 1'b0;
   logic          rst_n     = 1'b0;
   logic          in_valid  = 1'b0;
   logic          out_ready = 1'b0;
   logic [W-1:0]  a         = '0;
   logic [W-1:0]  b         = '0;

   logic          inReadyO  [3];
   logic          outValidO [3];
   logic          gtO       [3];
   logic          eqO       [3];
   logic          ltO       [3];
   logic [3:0]    cntO      [3];

   int            totalCnt = 0;
   int            passCnt  = 0;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [2:0]   flU;
      logic [2:0]   flS;
      logic [2:0]   flC;
      logic [3:0]   cnU;
      logic [3:0]   cnS;
   } vec_t;

   vec_t vecs [10];

   // Free-running clock.
   always #5 clk = ~clk;

   cmp_seq_ctrl #(.N_NIB(NN), .EARLY_EXIT(1), .SIGNED(0)) dutU (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(inReadyO[0]),
      .a(a), .b(b), .out_valid(outValidO[0]), .out_ready(out_ready),
      .gt(gtO[0]), .eq(eqO[0]), .lt(ltO[0]), .nib_cnt(cntO[0])
   );

   cmp_seq_ctrl #(.N_NIB(NN), .EARLY_EXIT(1), .SIGNED(1)) dutS (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(inReadyO[1]),
      .a(a), .b(b), .out_valid(outValidO[1]), .out_ready(out_ready),
      .gt(gtO[1]), .eq(eqO[1]), .lt(ltO[1]), .nib_cnt(cntO[1])
   );

   cmp_seq_ctrl #(.N_NIB(NN), .EARLY_EXIT(0), .SIGNED(0)) dutC (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(inReadyO[2]),
      .a(a), .b(b), .out_valid(outValidO[2]), .out_ready(out_ready),
      .gt(gtO[2]), .eq(eqO[2]), .lt(ltO[2]), .nib_cnt(cntO[2])
   );

   task automatic checkOutput(input string name, input int act, input int exp);
      totalCnt++;
      if (act == exp) begin
         passCnt++;
      end else begin
         $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
      end
   endtask

   // Reference: the answer is the integer ordering of the operands; with
   // early exit the compare count is the number of nibbles from the top down
   // to the one holding the highest differing bit.
   function automatic void refModel(input logic [W-1:0] av, input logic [W-1:0] bv,
                                    input bit sgn, input bit early,
                                    output logic [2:0] fl, output logic [3:0] cnt);
      int x;
      int y;
      int hb;
      logic [W-1:0] d;
      if (sgn) begin
         x = int'($signed(av));
         y = int'($signed(bv));
      end else begin
         x = int'({16'd0, av});
         y = int'({16'd0, bv});
      end
      fl = (x > y) ? GT : ((x == y) ? EQ : LT);
      d  = av ^ bv;
      hb = 0;
      for (int k = 0; k < W; k++) begin
         if (d[k]) hb = k;
      end
      if (!early || (av == bv)) cnt = 4'(NN);
      else                      cnt = 4'(NN - hb / 4);
   endfunction

   task automatic checkIdle(input string tag, input logic [2:0] eF[3], input logic [3:0] eC[3]);
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("%s idle[%0d]", tag, i),
                     int'({inReadyO[i], outValidO[i], gtO[i], eqO[i], ltO[i], cntO[i]}),
                     int'({1'b1, 1'b0, eF[i], eC[i]}));
      end
   endtask

   // One full operation on all three instances: handshake, wait for every
   // result, check flags/count/latency, optionally stall the consumer, then
   // release and check that results are retained in IDLE.
   task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                                input logic [2:0] eF0, input logic [2:0] eF1, input logic [2:0] eF2,
                                input logic [3:0] eC0, input logic [3:0] eC1, input logic [3:0] eC2,
                                input bit noisy, input int hold, input string tag);
      logic [2:0] eF [3];
      logic [3:0] eC [3];
      int         lat  [3];
      bit         seen [3];
      bit         allSeen;
      eF[0] = eF0; eF[1] = eF1; eF[2] = eF2;
      eC[0] = eC0; eC[1] = eC1; eC[2] = eC2;
      for (int i = 0; i < 3; i++) begin
         lat[i]  = 0;
         seen[i] = 1'b0;
      end
      allSeen = 1'b0;

      @(negedge clk);
      a         = av;
      b         = bv;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      if (noisy) begin
         a = W'($urandom);
         b = W'($urandom);
      end else begin
         in_valid = 1'b0;
      end

      for (int j = 1; j <= 20 && !allSeen; j++) begin
         @(posedge clk);
         #1;
         for (int i = 0; i < 3; i++) begin
            if (!seen[i] && outValidO[i]) begin
               seen[i] = 1'b1;
               lat[i]  = j;
            end
         end
         allSeen = seen[0] && seen[1] && seen[2];
         if (noisy) begin
            a = W'($urandom);
            b = W'($urandom);
         end
      end

      if (!allSeen) begin
         checkOutput({tag, " timeout"}, 0, 1);
         in_valid = 1'b0;
         rst_n    = 1'b0;
         @(negedge clk);
         rst_n    = 1'b1;
         return;
      end

      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("%s flags[%0d]", tag, i), int'({gtO[i], eqO[i], ltO[i]}), int'(eF[i]));
         checkOutput($sformatf("%s cnt[%0d]", tag, i), int'(cntO[i]), int'(eC[i]));
         checkOutput($sformatf("%s latency[%0d]", tag, i), lat[i], int'(eC[i]));
      end

      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         #1;
         for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("%s hold%0d[%0d]", tag, h, i),
                        int'({inReadyO[i], outValidO[i], gtO[i], eqO[i], ltO[i], cntO[i]}),
                        int'({1'b0, 1'b1, eF[i], eC[i]}));
         end
      end

      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checkIdle(tag, eF, eC);
   endtask

   initial begin
      logic [W-1:0] av;
      logic [W-1:0] bv;
      logic [2:0]   fU, fS, fC;
      logic [3:0]   cU, cS, cC;
      logic [2:0]   zF [3];
      logic [3:0]   zC [3];
      int           sawValid;

      vecs[0] = '{16'h1234, 16'h1235, LT, LT, LT, 4'd4, 4'd4};
      vecs[1] = '{16'h9000, 16'h1FFF, GT, LT, GT, 4'd1, 4'd1};
      vecs[2] = '{16'hA000, 16'h5000, GT, LT, GT, 4'd1, 4'd1};
      vecs[3] = '{16'hBEEF, 16'hBEEF, EQ, EQ, EQ, 4'd4, 4'd4};
      vecs[4] = '{16'h0003, 16'h0003, EQ, EQ, EQ, 4'd4, 4'd4};
      vecs[5] = '{16'h12F0, 16'h1200, GT, GT, GT, 4'd3, 4'd3};
      vecs[6] = '{16'h8000, 16'h7FFF, GT, LT, GT, 4'd1, 4'd1};
      vecs[7] = '{16'hFFFF, 16'h0000, GT, LT, GT, 4'd1, 4'd1};
      vecs[8] = '{16'h0001, 16'h0000, GT, GT, GT, 4'd4, 4'd4};
      vecs[9] = '{16'h7000, 16'h8000, LT, GT, LT, 4'd1, 4'd1};
      for (int i = 0; i < 3; i++) begin
         zF[i] = 3'b000;
         zC[i] = 4'd0;
      end

      // Reset state, checked while reset is still asserted.
      #12;
      checkIdle("reset", zF, zC);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors; the first one scrambles a/b with in_valid held
      // high during the compare, the BEEF one stalls the consumer.
      for (int v = 0; v < 10; v++) begin
         applyStimulus(vecs[v].a, vecs[v].b, vecs[v].flU, vecs[v].flS, vecs[v].flC,
                       vecs[v].cnU, vecs[v].cnS, 4'(NN),
                       (v == 0), (v == 3) ? 5 : 0, $sformatf("vec%0d", v));
      end

      // Reset in the second cycle of COMPARE aborts the operation.
      @(negedge clk);
      a        = 16'h1234;
      b        = 16'h1235;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkIdle("abort", zF, zC);
      @(negedge clk);
      rst_n    = 1'b1;
      sawValid = 0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk);
         #1;
         for (int i = 0; i < 3; i++) begin
            if (outValidO[i]) sawValid++;
         end
      end
      checkOutput("abort no out_valid", sawValid, 0);
      applyStimulus(16'h0003, 16'h0003, EQ, EQ, EQ, 4'd4, 4'd4, 4'd4, 1'b0, 0, "postReset");

      // Random operands, some sharing upper nibbles, against the model.
      for (int r = 0; r < 40; r++) begin
         av = W'($urandom);
         case (r % 4)
            0:       bv = W'($urandom);
            1:       bv = av;
            2:       bv = av ^ (W'(1) << $urandom_range(0, W - 1));
            default: bv = av ^ W'($urandom_range(0, 255));
         endcase
         refModel(av, bv, 1'b0, 1'b1, fU, cU);
         refModel(av, bv, 1'b1, 1'b1, fS, cS);
         refModel(av, bv, 1'b0, 1'b0, fC, cC);
         applyStimulus(av, bv, fU, fS, fC, cU, cS, cC, (r % 5 == 0), 0, $sformatf("rnd%0d", r));
      end

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
